// File: rtl/mem_copy_engine_pkg.sv
// Shared widths, length type and FSM state encoding for the memory block-copy engine.
// Consumed by mem_copy_engine (optional MEM_COPY_CHECKSUM_EN build) and its bus interface.
package mem_pkg;

  localparam int DEFAULT_ADDR_W = 8;
  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_LEN_W  = 8;

  typedef logic [DEFAULT_LEN_W-1:0] len_t;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    DONE,
    ABORT
  } copy_state_t;

endpackage

// File: rtl/mem_copy_engine_if.sv
// Data-memory port shared by the copy engine (master) and the 8-bit data memory (slave).
// MemData is the memory's registered read data, valid the cycle after MemRead.
interface mem_copy_engine_if
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
);

  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] Write_data;
  logic [DATA_W-1:0] MemData;

  modport master (
    output MemRead,
    output MemWrite,
    output Address,
    output Write_data,
    input  MemData
  );

  modport slave (
    input  MemRead,
    input  MemWrite,
    input  Address,
    input  Write_data,
    output MemData
  );

endinterface

// File: rtl/mem_copy_engine.sv
// Byte-at-a-time forward block copy over the data-memory port (read byte i, then write byte i).
// Define MEM_COPY_CHECKSUM_EN to add a running modulo-2^DATA_W sum of the bytes written.
module mem_copy_engine
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int LEN_W  = DEFAULT_LEN_W
) (
  input  logic              ph1,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  mem_copy_engine_if.master mem,
  output logic              busy,
  output logic              done,
  output logic              aborted
`ifdef MEM_COPY_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  copy_state_t       state;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic [LEN_W-1:0]  count;
  logic [ADDR_W-1:0] address;
  logic              mem_read;
  logic              mem_write;
  logic              accept;

  // abort outranks start, so a simultaneous abort keeps the engine idle
  assign accept = (state == IDLE) && start && !abort;

  // Strobes/address are registered alongside the state they belong to, so they
  // stay pure state decodes and drop immediately with the asynchronous reset.
  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      count     <= '0;
      address   <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      address   <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (length != '0) begin
              src_ptr  <= src_addr;
              dst_ptr  <= dst_addr;
              count    <= length;
              state    <= READ;
              mem_read <= 1'b1;
              address  <= src_addr;
              busy     <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        READ: begin
          if (abort) begin
            state   <= ABORT;
            aborted <= 1'b1;
          end else begin
            state     <= WRITE;
            mem_write <= 1'b1;
            address   <= dst_ptr;
            busy      <= 1'b1;
          end
        end
        WRITE: begin
          src_ptr <= src_ptr + ADDR_W'(1);
          dst_ptr <= dst_ptr + ADDR_W'(1);
          count   <= count - LEN_W'(1);
          if (abort) begin
            state   <= ABORT;
            aborted <= 1'b1;
          end else if (count == LEN_W'(1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state    <= READ;
            mem_read <= 1'b1;
            address  <= src_ptr + ADDR_W'(1);
            busy     <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        ABORT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem.MemRead    = mem_read;
  assign mem.MemWrite   = mem_write;
  assign mem.Address    = address;
  assign mem.Write_data = (state == WRITE) ? mem.MemData : '0;

`ifdef MEM_COPY_CHECKSUM_EN
  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= '0;
    end else if (state == WRITE) begin
      checksum <= checksum + mem.Write_data;
    end
  end
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed self-checking bench for mem_copy_engine with a registered-read data memory model.
// Checksum expectations are compiled in when MEM_COPY_CHECKSUM_EN is defined.
module tb_mem_copy_engine;
  import mem_pkg::*;

  logic       ph1 = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] src_addr = '0;
  logic [7:0] dst_addr = '0;
  len_t       length = '0;
  logic       busy;
  logic       done;
  logic       aborted;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  mem_copy_engine_if bus ();

  mem_copy_engine dut (
    .ph1      (ph1),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .length   (length),
    .mem      (bus),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted)
`ifdef MEM_COPY_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  always #5 ph1 = ~ph1;

  logic [7:0] mem [256];
  logic       pre_we = 1'b0;
  logic [7:0] pre_addr = '0;
  logic [7:0] pre_data = '0;

  // Data memory: registered read, write on MemWrite; pre_we is the bench's preload port
  always_ff @(posedge ph1) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bus.MemWrite) mem[bus.Address] <= bus.Write_data;
    if (bus.MemRead) bus.MemData <= mem[bus.Address];
  end

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] addr_log [$];
  int         done_cyc, done_cnt, abort_cnt, busy_cnt, rd_cnt, wr_cnt;
  bit         timed_out;

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    @(posedge ph1); #1;
    pre_we   = 1'b0;
  endtask

  // Cycle 1 is the cycle right after the accepting edge; stops two cycles after done/aborted.
  task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input len_t l,
                          input int abort_cyc, input int restart_cyc);
    int tail;
    tail = -1;
    addr_log.delete();
    done_cyc = 0; done_cnt = 0; abort_cnt = 0; busy_cnt = 0; rd_cnt = 0; wr_cnt = 0;
    timed_out = 1'b1;
    src_addr = s; dst_addr = d; length = l; start = 1'b1;
    @(posedge ph1); #1;
    start = 1'b0; src_addr = ~s; dst_addr = ~d; length = ~l;
    for (int cyc = 1; cyc <= 64; cyc++) begin
      abort = (cyc == abort_cyc);
      start = (cyc == restart_cyc);
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (aborted) abort_cnt++;
      if (busy) busy_cnt++;
      if (bus.MemRead) rd_cnt++;
      if (bus.MemWrite) wr_cnt++;
      if (bus.MemRead || bus.MemWrite) addr_log.push_back(bus.Address);
      if (tail < 0 && (done || aborted)) tail = 2;
      else if (tail > 0) tail--;
      if (tail == 0) begin timed_out = 1'b0; break; end
      @(posedge ph1); #1;
    end
    abort = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    vectors++; if (bus.MemRead !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_MemRead: got %b expected 0", bus.MemRead); end
    vectors++; if (bus.MemWrite !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_MemWrite: got %b expected 0", bus.MemWrite); end
    vectors++; if (bus.Address !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_Address: got %h expected 00", bus.Address); end
    vectors++; if (bus.Write_data !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_Write_data: got %h expected 00", bus.Write_data); end
    vectors++; if ({busy, done, aborted} !== 3'b000) begin miscompares++; $display("[TB] FAIL reset_status: got %b expected 000", {busy, done, aborted}); end
`ifdef MEM_COPY_CHECKSUM_EN
    vectors++; if (checksum !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_checksum: got %h expected 00", checksum); end
`endif
    @(posedge ph1); #1;
    reset = 1'b0;
    @(posedge ph1); #1;
  endtask

  task automatic test_basic_copy();
    logic [7:0] exp_b [4];
    exp_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    for (int i = 0; i < 4; i++) begin
      poke(8'(8'h10 + i), exp_b[i]);
      poke(8'(8'h40 + i), 8'h00);
    end
    run_copy(8'h10, 8'h40, 8'd4, 0, 0);
    vectors++; if (timed_out !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_timeout: got %b expected 0", timed_out); end
    for (int i = 0; i < 4; i++) begin
      vectors++; if (mem[8'(8'h40 + i)] !== exp_b[i]) begin miscompares++; $display("[TB] FAIL basic_mem[%0d]: got %h expected %h", i, mem[8'(8'h40 + i)], exp_b[i]); end
    end
    vectors++; if (done_cyc !== 9) begin miscompares++; $display("[TB] FAIL basic_done_cycle: got %0d expected 9", done_cyc); end
    vectors++; if (done_cnt !== 1) begin miscompares++; $display("[TB] FAIL basic_done_pulses: got %0d expected 1", done_cnt); end
    vectors++; if (busy_cnt !== 8) begin miscompares++; $display("[TB] FAIL basic_busy_cycles: got %0d expected 8", busy_cnt); end
    vectors++; if (rd_cnt !== 4 || wr_cnt !== 4) begin miscompares++; $display("[TB] FAIL basic_strobes: got rd=%0d wr=%0d expected 4/4", rd_cnt, wr_cnt); end
    vectors++; if (abort_cnt !== 0) begin miscompares++; $display("[TB] FAIL basic_aborted: got %0d expected 0", abort_cnt); end
`ifdef MEM_COPY_CHECKSUM_EN
    vectors++; if (checksum !== 8'h0E) begin miscompares++; $display("[TB] FAIL basic_checksum: got %h expected 0e", checksum); end
`endif
  endtask

  task automatic test_zero_length();
    run_copy(8'h30, 8'h31, 8'd0, 0, 0);
    vectors++; if (timed_out !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_timeout: got %b expected 0", timed_out); end
    vectors++; if (rd_cnt !== 0 || wr_cnt !== 0) begin miscompares++; $display("[TB] FAIL zero_strobes: got rd=%0d wr=%0d expected 0/0", rd_cnt, wr_cnt); end
    vectors++; if (done_cyc !== 1) begin miscompares++; $display("[TB] FAIL zero_done_cycle: got %0d expected 1", done_cyc); end
    vectors++; if (done_cnt !== 1) begin miscompares++; $display("[TB] FAIL zero_done_pulses: got %0d expected 1", done_cnt); end
    vectors++; if (busy_cnt !== 0) begin miscompares++; $display("[TB] FAIL zero_busy: got %0d expected 0", busy_cnt); end
`ifdef MEM_COPY_CHECKSUM_EN
    vectors++; if (checksum !== 8'h00) begin miscompares++; $display("[TB] FAIL zero_checksum: got %h expected 00", checksum); end
`endif
  endtask

  task automatic test_wrap();
    logic [7:0] exp_seq [6];
    exp_seq = '{8'hFE, 8'h20, 8'hFF, 8'h21, 8'h00, 8'h22};
    poke(8'hFE, 8'h01); poke(8'hFF, 8'h02); poke(8'h00, 8'h03);
    poke(8'h20, 8'h00); poke(8'h21, 8'h00); poke(8'h22, 8'h00);
    run_copy(8'hFE, 8'h20, 8'd3, 0, 0);
    vectors++; if (timed_out !== 1'b0) begin miscompares++; $display("[TB] FAIL wrap_timeout: got %b expected 0", timed_out); end
    vectors++; if ({mem[8'h20], mem[8'h21], mem[8'h22]} !== 24'h010203) begin miscompares++; $display("[TB] FAIL wrap_mem: got %h expected 010203", {mem[8'h20], mem[8'h21], mem[8'h22]}); end
    vectors++; if (addr_log.size() !== 6) begin miscompares++; $display("[TB] FAIL wrap_addr_count: got %0d expected 6", addr_log.size()); end
    for (int i = 0; i < 6 && i < addr_log.size(); i++) begin
      vectors++; if (addr_log[i] !== exp_seq[i]) begin miscompares++; $display("[TB] FAIL wrap_addr[%0d]: got %h expected %h", i, addr_log[i], exp_seq[i]); end
    end
  endtask

  task automatic test_overlap();
    poke(8'h50, 8'h5A); poke(8'h51, 8'h11); poke(8'h52, 8'h22); poke(8'h53, 8'h33);
    run_copy(8'h50, 8'h51, 8'd3, 0, 0);
    vectors++; if (timed_out !== 1'b0) begin miscompares++; $display("[TB] FAIL overlap_timeout: got %b expected 0", timed_out); end
    vectors++; if ({mem[8'h51], mem[8'h52], mem[8'h53]} !== 24'h5A5A5A) begin miscompares++; $display("[TB] FAIL overlap_mem: got %h expected 5a5a5a", {mem[8'h51], mem[8'h52], mem[8'h53]}); end
  endtask

  task automatic test_abort();
    for (int i = 0; i < 5; i++) begin
      poke(8'(8'h60 + i), 8'(8'h11 * (i + 1)));
      poke(8'(8'h80 + i), 8'hEE);
    end
    // cycle 5 is the READ of byte 2
    run_copy(8'h60, 8'h80, 8'd5, 5, 0);
    vectors++; if (timed_out !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_rd_timeout: got %b expected 0", timed_out); end
    vectors++; if ({mem[8'h80], mem[8'h81], mem[8'h82]} !== 24'h1122EE) begin miscompares++; $display("[TB] FAIL abort_rd_mem: got %h expected 1122ee", {mem[8'h80], mem[8'h81], mem[8'h82]}); end
    vectors++; if (abort_cnt !== 1 || done_cnt !== 0) begin miscompares++; $display("[TB] FAIL abort_rd_pulses: got aborted=%0d done=%0d expected 1/0", abort_cnt, done_cnt); end
    vectors++; if (wr_cnt !== 2) begin miscompares++; $display("[TB] FAIL abort_rd_writes: got %0d expected 2", wr_cnt); end
`ifdef MEM_COPY_CHECKSUM_EN
    vectors++; if (checksum !== 8'h33) begin miscompares++; $display("[TB] FAIL abort_rd_checksum: got %h expected 33", checksum); end
`endif
    for (int i = 0; i < 5; i++) poke(8'(8'h80 + i), 8'hEE);
    // cycle 6 is the WRITE of byte 2
    run_copy(8'h60, 8'h80, 8'd5, 6, 0);
    vectors++; if (timed_out !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_wr_timeout: got %b expected 0", timed_out); end
    vectors++; if ({mem[8'h80], mem[8'h81], mem[8'h82], mem[8'h83]} !== 32'h112233EE) begin miscompares++; $display("[TB] FAIL abort_wr_mem: got %h expected 112233ee", {mem[8'h80], mem[8'h81], mem[8'h82], mem[8'h83]}); end
    vectors++; if (abort_cnt !== 1 || done_cnt !== 0) begin miscompares++; $display("[TB] FAIL abort_wr_pulses: got aborted=%0d done=%0d expected 1/0", abort_cnt, done_cnt); end
    vectors++; if (wr_cnt !== 3) begin miscompares++; $display("[TB] FAIL abort_wr_writes: got %0d expected 3", wr_cnt); end
`ifdef MEM_COPY_CHECKSUM_EN
    vectors++; if (checksum !== 8'h66) begin miscompares++; $display("[TB] FAIL abort_wr_checksum: got %h expected 66", checksum); end
`endif
  endtask

  task automatic test_async_reset();
    poke(8'h90, 8'h00); poke(8'h91, 8'h00);
    src_addr = 8'h10; dst_addr = 8'h90; length = 8'd4; start = 1'b1;
    @(posedge ph1); #1;
    start = 1'b0;
    // advance to cycle 4, the WRITE of byte 1
    repeat (3) begin @(posedge ph1); #1; end
    vectors++; if (bus.MemWrite !== 1'b1) begin miscompares++; $display("[TB] FAIL arst_pre_MemWrite: got %b expected 1", bus.MemWrite); end
    #2 reset = 1'b1;
    #1;
    vectors++; if (bus.MemWrite !== 1'b0) begin miscompares++; $display("[TB] FAIL arst_MemWrite: got %b expected 0", bus.MemWrite); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL arst_busy: got %b expected 0", busy); end
    vectors++; if (bus.Address !== 8'h00 || bus.Write_data !== 8'h00) begin miscompares++; $display("[TB] FAIL arst_bus: got addr=%h data=%h expected 00/00", bus.Address, bus.Write_data); end
`ifdef MEM_COPY_CHECKSUM_EN
    vectors++; if (checksum !== 8'h00) begin miscompares++; $display("[TB] FAIL arst_checksum: got %h expected 00", checksum); end
`endif
    @(posedge ph1); #1;
    reset = 1'b0;
    @(posedge ph1); #1;
    vectors++; if ({mem[8'h90], mem[8'h91]} !== 16'hAA00) begin miscompares++; $display("[TB] FAIL arst_mem: got %h expected aa00", {mem[8'h90], mem[8'h91]}); end
  endtask

  task automatic test_start_while_busy();
    poke(8'hA0, 8'h00); poke(8'hA1, 8'h00); poke(8'hB0, 8'h00); poke(8'h5F, 8'h00);
    // a second start (with scrambled operands, dst 0x5F) arrives in cycle 2
    run_copy(8'h10, 8'hA0, 8'd2, 0, 2);
    vectors++; if (timed_out !== 1'b0) begin miscompares++; $display("[TB] FAIL busy_start_timeout: got %b expected 0", timed_out); end
    vectors++; if ({mem[8'hA0], mem[8'hA1]} !== 16'hAABB) begin miscompares++; $display("[TB] FAIL busy_start_mem: got %h expected aabb", {mem[8'hA0], mem[8'hA1]}); end
    vectors++; if (done_cyc !== 5 || done_cnt !== 1) begin miscompares++; $display("[TB] FAIL busy_start_done: got cyc=%0d cnt=%0d expected 5/1", done_cyc, done_cnt); end
    vectors++; if (wr_cnt !== 2 || mem[8'h5F] !== 8'h00) begin miscompares++; $display("[TB] FAIL busy_start_ignored: got wr=%0d mem5f=%h expected 2/00", wr_cnt, mem[8'h5F]); end
    run_copy(8'h12, 8'hB0, 8'd1, 0, 0);
    vectors++; if (mem[8'hB0] !== 8'hCC) begin miscompares++; $display("[TB] FAIL idle_start_mem: got %h expected cc", mem[8'hB0]); end
    vectors++; if (done_cyc !== 3 || done_cnt !== 1) begin miscompares++; $display("[TB] FAIL idle_start_done: got cyc=%0d cnt=%0d expected 3/1", done_cyc, done_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic_copy();
    test_zero_length();
    test_wrap();
    test_overlap();
    test_abort();
    test_async_reset();
    test_start_while_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
- Bus initiator that drives the 8-bit data memory's MemRead/MemWrite/Address/Write_data port and consumes its registered MemData.
- Copies a block of `length` bytes from `src_addr` to `dst_addr`, one byte at a time, in forward order.
- Sits beside the control unit as a block-move helper. While it is busy it is the sole owner of the memory port; the external mux is controlled by `busy|done`.

Parameters:
- ADDR_W, 8, address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 8, memory data width.
- LEN_W, 8, length field width; maximum copy is 2^LEN_W-1 bytes.

Ports:
- ph1  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a copy; sampled only in IDLE.
- abort  in  1  synchronous cancel of an in-flight copy.
- src_addr  in  ADDR_W  source base address; latched when start is accepted.
- dst_addr  in  ADDR_W  destination base address; latched when start is accepted.
- length  in  LEN_W  byte count; latched when start is accepted.
- MemData  in  DATA_W  memory read data; valid in the cycle after MemRead was high.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- Address  out  ADDR_W  memory address.
- Write_data  out  DATA_W  memory write data.
- busy  out  1  high in READ and WRITE.
- done  out  1  one-cycle completion pulse.
- aborted  out  1  one-cycle abort pulse.

Behaviour:
- States: IDLE, READ, WRITE, DONE, ABORT. State register is reset asynchronously to IDLE.
- Reset values: all outputs 0; internal src_ptr, dst_ptr and count cleared to 0.
- Strobes are decoded from state (Moore). In IDLE, DONE and ABORT: MemRead=0, MemWrite=0, Address=0, Write_data=0.
- IDLE:
  - start=1 and length!=0: latch src_ptr, dst_ptr, count; go to READ.
  - start=1 and length=0: go to DONE with no memory traffic.
  - Otherwise stay in IDLE.
- READ: MemRead=1, Address=src_ptr. Next state is WRITE.
- WRITE:
  - Outputs: MemWrite=1, MemRead=0, Address=dst_ptr, Write_data=MemData (the byte read in the preceding cycle, passed straight through).
  - On exit: src_ptr+1, dst_ptr+1 (each mod 2^ADDR_W), count-1.
  - Go to DONE if count was 1, else to READ.
- DONE: done=1 for exactly one cycle, then IDLE.
- ABORT: aborted=1 for exactly one cycle, then IDLE.
- Timing: each byte takes 2 cycles. For N>0, done goes high 2N+1 cycles after the edge that accepted start. For N=0, done goes high 1 cycle after that edge.
- abort=1 in READ:
  - Go to ABORT. No write is issued for that byte.
  - All previously completed bytes stay written.
- abort=1 in WRITE: the write of that byte completes, then go to ABORT instead of READ/DONE.
- abort=1 in IDLE or DONE: ignored. abort has priority over start.
- start in any state other than IDLE is ignored. The length, src_addr and dst_addr inputs may change freely after acceptance.
- Overlapping regions: strict byte-by-byte forward semantics (read byte i, then write byte i). If dst_ptr=src_ptr+1, the first byte propagates through the region; this is intended.
- Pointer wrap: 0xFF+1 yields 0x00 with no error.
- Reset asserted mid-copy: immediate return to IDLE and strobes deassert without waiting for a clock edge. Memory contents already written remain.

Optional Feature:
- Macro: MEM_COPY_CHECKSUM_EN.
- Defined:
  - Adds output `checksum`, DATA_W wide.
  - Cleared when start is accepted.
  - In each WRITE cycle, adds Write_data modulo 2^DATA_W.
  - Holds its value after DONE/ABORT until the next accepted start or reset.
  - Reset value is 0.
- Undefined: no checksum port or logic. All other behaviour is identical.

Decomposition:
- Shared package mem_pkg holds:
  - ADDR_W and DATA_W defaults.
  - The state enum copy_state_t (IDLE, READ, WRITE, DONE, ABORT).
  - The length-type typedef.
- No sub-module is needed. The FSM and pointer/counter datapath live in one module. The checksum accumulator is an inline block under the macro.

Test Plan:
- Preload mem[0x10..0x13]=AA,BB,CC,DD; src=0x10, dst=0x40, len=4 -> mem[0x40..0x43]=AA,BB,CC,DD; done high exactly 9 cycles after start edge; busy high 8 cycles; with macro, checksum=0x0E.
- len=0, start=1 -> no MemRead/MemWrite ever high; done pulses the next cycle.
- src=0xFE, dst=0x20, len=3, mem[FE,FF,00]=01,02,03 -> mem[0x20..0x22]=01,02,03; Address sequence FE,20,FF,21,00,22.
- Overlap: mem[0x50]=5A, src=0x50, dst=0x51, len=3 -> mem[0x51..0x53]=5A,5A,5A.
- len=5, abort asserted in the READ cycle of byte 2 -> bytes 0..1 copied, dst+2 untouched; aborted pulses once; done never pulses. Repeat with abort in the WRITE cycle of byte 2 -> bytes 0..2 copied.
- Assert reset asynchronously mid-WRITE -> MemWrite falls before the next ph1 edge; busy=0. A start during busy is ignored; a start after return to IDLE is accepted.
